// File: rtl/hazard_scoreboard.sv
// Multi-lane issue scoreboard: per-register countdown of pending producer latency,
// resolving RAW/WAW/intra-bundle hazards and issuing the oldest independent prefix.
module hazard_scoreboard #(
    parameter int ISSUE_WIDTH = 2,
    parameter int NREG        = 32,
    parameter int LAT_W       = 3,
    parameter int PERF_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         ex_stall_i,
    input  logic [ISSUE_WIDTH-1:0]       de_valid_i,
    input  logic [ISSUE_WIDTH*5-1:0]     de_rs_i,
    input  logic [ISSUE_WIDTH*5-1:0]     de_rt_i,
    input  logic [ISSUE_WIDTH*5-1:0]     de_rd_i,
    input  logic [ISSUE_WIDTH-1:0]       de_we_i,
    input  logic [ISSUE_WIDTH*LAT_W-1:0] de_lat_i,
    output logic [ISSUE_WIDTH-1:0]       issue_mask_o,
    output logic                         if_stall_o,
    output logic                         id_stall_o,
    output logic                         ex_stall_o,
    output logic [PERF_W-1:0]            stall_cycles_o
);

    logic [4:0]       rs  [ISSUE_WIDTH];
    logic [4:0]       rt  [ISSUE_WIDTH];
    logic [4:0]       rd  [ISSUE_WIDTH];
    logic [LAT_W-1:0] lat [ISSUE_WIDTH];

    logic [LAT_W-1:0] cnt      [NREG];
    logic [LAT_W-1:0] cnt_next [NREG];
    logic [LAT_W-1:0] cnt_view [32];

    logic [ISSUE_WIDTH-1:0] blocked;
    logic                   raw;
    logic                   waw;
    logic                   intra;
    logic                   lane_blk;
    logic                   prior_blk;
    logic                   stall;

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rs[i]  = de_rs_i[5*i +: 5];
            rt[i]  = de_rt_i[5*i +: 5];
            rd[i]  = de_rd_i[5*i +: 5];
            lat[i] = de_lat_i[LAT_W*i +: LAT_W];
        end
    end

    // Full 32-entry view so any 5-bit register field can index it; r0 and unused regs read 0.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_view[r] = '0;
        end
        for (int r = 1; r < NREG && r < 32; r++) begin
            cnt_view[r] = cnt[r];
        end
    end

    always_comb begin
        blocked   = '0;
        raw       = 1'b0;
        waw       = 1'b0;
        intra     = 1'b0;
        lane_blk  = 1'b0;
        prior_blk = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            raw = (rs[i] != '0 && cnt_view[rs[i]] != '0) ||
                  (rt[i] != '0 && cnt_view[rt[i]] != '0);
            waw = de_we_i[i] && rd[i] != '0 && (cnt_view[rd[i]] > lat[i]);
            intra = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (de_valid_i[j] && de_we_i[j] && rd[j] != '0 && lat[j] != '0 &&
                    (rd[j] == rs[i] || rd[j] == rt[i])) begin
                    intra = 1'b1;
                end
            end
            lane_blk   = raw | waw | intra | prior_blk;
            blocked[i] = lane_blk;
            // Any valid blocked lane stops every younger lane to keep issue in order.
            prior_blk  = prior_blk | (de_valid_i[i] & lane_blk);
        end
    end

    assign issue_mask_o = de_valid_i & ~blocked & {ISSUE_WIDTH{~ex_stall_i & ~flush_i}};
    assign stall        = ~flush_i & (ex_stall_i | (|(de_valid_i & ~issue_mask_o)));
    assign if_stall_o   = stall;
    assign id_stall_o   = stall;
    assign ex_stall_o   = 1'b0;

    // Ascending lane order lets the youngest issued writer of a register win.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_next[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
        end
        cnt_next[0] = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            for (int r = 1; r < NREG && r < 32; r++) begin
                if (issue_mask_o[i] && de_we_i[i] && rd[i] == 5'(r)) begin
                    cnt_next[r] = lat[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            stall_cycles_o <= '0;
        end else begin
            if (stall && stall_cycles_o != '1) begin
                stall_cycles_o <= stall_cycles_o + PERF_W'(1);
            end
            if (flush_i) begin
                for (int r = 0; r < NREG; r++) begin
                    cnt[r] <= '0;
                end
            end else if (!ex_stall_i) begin
                for (int r = 0; r < NREG; r++) begin
                    cnt[r] <= cnt_next[r];
                end
            end
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the single-lane load-use stall controller. Tracks pending register writes from multi-cycle producers (load, mul/div, CP0) with a per-register countdown scoreboard. Resolves RAW and WAW hazards across ISSUE_WIDTH decode lanes, and issues the oldest independent prefix of the bundle. Sits between decode and issue, and drives the IF/ID/EX stall lines.

Parameters:
ISSUE_WIDTH, 2, decode lanes per cycle (1..4); lane 0 is oldest.
NREG, 32, architectural registers; register 0 is hardwired zero.
LAT_W, 3, width of latency field and per-register counters.
PERF_W, 32, width of stall-cycle performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush_i  in  1  pipeline flush (branch mispredict/exception).
ex_stall_i  in  1  back-end stall (multi-cycle EX busy).
de_valid_i  in  ISSUE_WIDTH  lane holds a valid instruction.
de_rs_i  in  ISSUE_WIDTH*5  source 1 per lane; lane i at [5i+4:5i].
de_rt_i  in  ISSUE_WIDTH*5  source 2 per lane.
de_rd_i  in  ISSUE_WIDTH*5  destination per lane.
de_we_i  in  ISSUE_WIDTH  lane writes de_rd.
de_lat_i  in  ISSUE_WIDTH*LAT_W  cycles consumers must wait after issue (load=1, mul=3; 0 means fully forwardable).
issue_mask_o  out  ISSUE_WIDTH  lanes issuing this cycle.
if_stall_o  out  1  hold fetch.
id_stall_o  out  1  hold decode (unissued lanes remain).
ex_stall_o  out  1  always 0; reserved.
stall_cycles_o  out  PERF_W  saturating count of cycles with id_stall_o=1.

Behaviour:
- State: cnt[r], r=1..NREG-1, each LAT_W bits. cnt[0] is constant 0.
- Priority: rst > flush_i > ex_stall_i > normal operation.
- rst: all cnt=0, stall_cycles_o=0. Outputs are combinational from state, so after reset issue_mask_o=de_valid_i and the stall outputs are 0.
- flush_i=1: all cnt cleared next edge; issue_mask_o=0, if/id_stall_o=0 this cycle; no counter update from lanes.
- ex_stall_i=1 (no flush): cnt frozen; issue_mask_o=0; if_stall_o=id_stall_o=1.
- Per-lane blocked[i] (combinational) is true if any of:
  - raw: (rs!=0 && cnt[rs]!=0) || (rt!=0 && cnt[rt]!=0);
  - waw: de_we && rd!=0 && cnt[rd] > de_lat[i];
  - intra: some older lane j<i with valid, we, rd_j!=0, rd_j in {rs_i, rt_i} and de_lat[j]!=0;
  - in-order: blocked[j] for any valid j<i.
- issue_mask_o[i] = de_valid[i] & ~blocked[i] & ~ex_stall_i & ~flush_i.
- id_stall_o = if_stall_o = ex_stall_i | OR over i of (de_valid[i] & ~issue_mask_o[i]), when flush_i=0.
- Counter update (flush_i=0, ex_stall_i=0), per edge:
  - each nonzero cnt decrements by 1;
  - each issued lane with we and rd!=0 then loads cnt[rd] = de_lat[i]; the load overrides the decrement;
  - two issued lanes with the same rd: the youngest lane's de_lat wins.
- Load-use timing: load issued at t with lat=1 gives cnt=1 at t+1; a dependent instruction stalls exactly one cycle and issues at t+2.
- stall_cycles_o increments on each edge with id_stall_o=1 and saturates at all-ones. Flush does not clear it.
- Lane inputs with de_valid=0 are ignored entirely.

Test Plan:
- Load-use: lane0 "lw r5" lat=1 issues at cycle 0; cycle 1 lane0 "add r6,r5,r1" -> issue_mask=00 and id_stall=1 for 1 cycle; issues at cycle 2; stall_cycles_o=1.
- Intra-bundle: lane0 writes r3 lat=1, lane1 reads r3 -> issue_mask=01, id_stall=1. Next cycle lane1 stalls once more, then issues.
- Long latency plus freeze: mul writes r8 lat=3, consumer waits 3 cycles. Assert ex_stall_i for 2 cycles mid-wait -> total wait 5 cycles, cnt[8] holds during the freeze.
- Register 0 and WAW: load lat=2 to r0 then a reader of r0 -> no stall. Writer r4 lat=3, then a lat=0 write to r4 the next cycle -> blocked until cnt[4]=0.
- Flush: r9 pending with cnt=3, flush_i asserted -> next cycle a reader of r9 issues immediately; during the flush cycle issue_mask=0 and if/id_stall=0.
- ISSUE_WIDTH=4 in-order: lane1 blocked -> lanes 2 and 3 are not issued even if independent; issue_mask=0001. Also rst mid-stall clears everything within 1 edge.
